// File: rtl/cmp_result_decoder_if.sv
// Operand/flag input channel, result output channel, counter clear and
// statistics outputs of the comparator result decoder.
interface cmp_result_decoder_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             agt;
  logic             bgt;
  logic             cgt;
  logic             dgt;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       win_idx;
  logic [WIDTH-1:0] win_val;
  logic             all_tie;
  logic             flag_err;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] tie_cnt;
  logic [CNT_W-1:0] err_cnt;

  // Upstream comparator + downstream consumer side
  modport master (
    output in_valid, a, b, c, d, agt, bgt, cgt, dgt, out_ready, clr_cnt,
    input  in_ready, out_valid, win_idx, win_val, all_tie, flag_err,
    input  cnt_a, cnt_b, cnt_c, cnt_d, tie_cnt, err_cnt
  );

  // Decoder side
  modport slave (
    input  in_valid, a, b, c, d, agt, bgt, cgt, dgt, out_ready, clr_cnt,
    output in_ready, out_valid, win_idx, win_val, all_tie, flag_err,
    output cnt_a, cnt_b, cnt_c, cnt_d, tie_cnt, err_cnt
  );
endinterface

// File: rtl/cmp_result_decoder.sv
// Receives the four operands plus winner flags from the max comparator,
// validates the flags against the operands, decodes winner index/value and
// keeps saturating per-input win, tie and error statistics.
//
// state   | meaning
// S_EMPTY | output register holds nothing, ready for a word
// S_FULL  | decoded result presented, waiting for out_ready
module cmp_result_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmp_result_decoder_if.slave  bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [1:0]       r_win_idx;
  logic [WIDTH-1:0] r_win_val;
  logic             r_all_tie;
  logic             r_flag_err;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [CNT_W-1:0] r_cnt_c;
  logic [CNT_W-1:0] r_cnt_d;
  logic [CNT_W-1:0] r_tie_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [3:0]       w_flags;
  logic             w_all_eq;
  logic [1:0]       w_ref_idx;
  logic [WIDTH-1:0] w_ref_max;
  logic [1:0]       w_dec_idx;
  logic [WIDTH-1:0] w_dec_val;
  logic             w_dec_tie;
  logic             w_dec_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_flags    = {bus.agt, bus.bgt, bus.cgt, bus.dgt};
  assign w_all_eq   = (bus.a == bus.b) && (bus.b == bus.c) && (bus.c == bus.d);

  // Reference winner: strict-greater scan, so the lowest index keeps a partial tie
  always_comb begin
    w_ref_idx = 2'd0;
    w_ref_max = bus.a;
    if (bus.b > w_ref_max) begin
      w_ref_idx = 2'd1;
      w_ref_max = bus.b;
    end
    if (bus.c > w_ref_max) begin
      w_ref_idx = 2'd2;
      w_ref_max = bus.c;
    end
    if (bus.d > w_ref_max) begin
      w_ref_idx = 2'd3;
    end
  end

  // Flag decode and consistency check; a full tie must be signalled as 1111
  always_comb begin
    w_dec_idx = 2'd0;
    w_dec_val = '0;
    w_dec_tie = 1'b0;
    w_dec_err = 1'b1;
    case (w_flags)
      4'b1000: begin
        w_dec_idx = 2'd0;
        w_dec_val = bus.a;
        w_dec_err = (w_ref_idx != 2'd0) || w_all_eq;
      end
      4'b0100: begin
        w_dec_idx = 2'd1;
        w_dec_val = bus.b;
        w_dec_err = (w_ref_idx != 2'd1);
      end
      4'b0010: begin
        w_dec_idx = 2'd2;
        w_dec_val = bus.c;
        w_dec_err = (w_ref_idx != 2'd2);
      end
      4'b0001: begin
        w_dec_idx = 2'd3;
        w_dec_val = bus.d;
        w_dec_err = (w_ref_idx != 2'd3);
      end
      4'b1111: begin
        w_dec_idx = 2'd0;
        w_dec_val = bus.a;
        w_dec_tie = w_all_eq;
        w_dec_err = !w_all_eq;
      end
      default: begin
        w_dec_idx = 2'd0;
        w_dec_val = '0;
        w_dec_tie = 1'b0;
        w_dec_err = 1'b1;
      end
    endcase
  end

  // One-entry output register FSM; reload on the same edge the old result leaves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_win_idx   <= 2'd0;
      r_win_val   <= '0;
      r_all_tie   <= 1'b0;
      r_flag_err  <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state     <= S_FULL;
            r_out_valid <= 1'b1;
            r_win_idx   <= w_dec_idx;
            r_win_val   <= w_dec_val;
            r_all_tie   <= w_dec_tie;
            r_flag_err  <= w_dec_err;
          end
        end
        S_FULL: begin
          if (w_accept) begin
            r_win_idx   <= w_dec_idx;
            r_win_val   <= w_dec_val;
            r_all_tie   <= w_dec_tie;
            r_flag_err  <= w_dec_err;
          end else if (bus.out_ready) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Saturating statistics, bumped only on accept; clear wins over an increment
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr_cnt) begin
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      r_cnt_c   <= '0;
      r_cnt_d   <= '0;
      r_tie_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_accept) begin
      if (w_dec_err) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end else if (w_dec_tie) begin
        r_tie_cnt <= sat_inc(r_tie_cnt);
      end else begin
        case (w_dec_idx)
          2'd0:    r_cnt_a <= sat_inc(r_cnt_a);
          2'd1:    r_cnt_b <= sat_inc(r_cnt_b);
          2'd2:    r_cnt_c <= sat_inc(r_cnt_c);
          default: r_cnt_d <= sat_inc(r_cnt_d);
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.win_idx   = r_win_idx;
  assign bus.win_val   = r_win_val;
  assign bus.all_tie   = r_all_tie;
  assign bus.flag_err  = r_flag_err;
  assign bus.cnt_a     = r_cnt_a;
  assign bus.cnt_b     = r_cnt_b;
  assign bus.cnt_c     = r_cnt_c;
  assign bus.cnt_d     = r_cnt_d;
  assign bus.tie_cnt   = r_tie_cnt;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_cmp_result_decoder.sv
// Directed bench for cmp_result_decoder: one 8-bit-counter instance for the
// decode/handshake/reset behaviour and one 2-bit-counter instance for
// saturation and clear.
module tb_cmp_result_decoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cmp_result_decoder_if #(.WIDTH(4), .CNT_W(8)) cb ();
  cmp_result_decoder_if #(.WIDTH(4), .CNT_W(2)) sb ();

  cmp_result_decoder #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cb)
  );

  cmp_result_decoder #(.WIDTH(4), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input logic [3:0] f);
    cb.a = a; cb.b = b; cb.c = c; cb.d = d;
    {cb.agt, cb.bgt, cb.cgt, cb.dgt} = f;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [3:0] d, input logic [3:0] f);
    set_word(a, b, c, d, f);
    cb.in_valid = 1'b1;
    tick();
    cb.in_valid = 1'b0;
  endtask

  task automatic send_s(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] f);
    sb.a = a; sb.b = b; sb.c = c; sb.d = d;
    {sb.agt, sb.bgt, sb.cgt, sb.dgt} = f;
    sb.in_valid = 1'b1;
    tick();
    sb.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    cb.in_valid = 1'b0; cb.out_ready = 1'b1; cb.clr_cnt = 1'b0;
    sb.in_valid = 1'b0; sb.out_ready = 1'b1; sb.clr_cnt = 1'b0;
    set_word(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    sb.a = '0; sb.b = '0; sb.c = '0; sb.d = '0;
    {sb.agt, sb.bgt, sb.cgt, sb.dgt} = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    check("rst_out_valid", cb.out_valid, 0);
    check("rst_win_idx",   cb.win_idx,   0);
    check("rst_win_val",   cb.win_val,   0);
    check("rst_all_tie",   cb.all_tie,   0);
    check("rst_flag_err",  cb.flag_err,  0);
    check("rst_cnt_b",     cb.cnt_b,     0);
    check("rst_in_ready",  cb.in_ready,  1);

    // legal one-hot b, partial tie with d goes to lower index... b wins strictly
    send(4'd3, 4'd9, 4'd2, 4'd9, 4'b0100);
    check("t1_out_valid", cb.out_valid, 1);
    check("t1_idx",       cb.win_idx,   1);
    check("t1_val",       cb.win_val,   9);
    check("t1_err",       cb.flag_err,  0);
    check("t1_cnt_b",     cb.cnt_b,     1);

    // full tie flagged correctly, then the same operands with a one-hot flag
    send(4'd5, 4'd5, 4'd5, 4'd5, 4'b1111);
    check("t2_tie",     cb.all_tie, 1);
    check("t2_idx",     cb.win_idx, 0);
    check("t2_val",     cb.win_val, 5);
    check("t2_err",     cb.flag_err, 0);
    check("t2_tie_cnt", cb.tie_cnt, 1);
    send(4'd5, 4'd5, 4'd5, 4'd5, 4'b1000);
    check("t2b_err",     cb.flag_err, 1);
    check("t2b_tie",     cb.all_tie,  0);
    check("t2b_val",     cb.win_val,  5);
    check("t2b_err_cnt", cb.err_cnt,  1);
    check("t2b_cnt_a",   cb.cnt_a,    0);

    // illegal pattern, and a one-hot that disagrees with operands
    send(4'd1, 4'd2, 4'd3, 4'd4, 4'b0110);
    check("t3_err",     cb.flag_err, 1);
    check("t3_idx",     cb.win_idx,  0);
    check("t3_val",     cb.win_val,  0);
    check("t3_err_cnt", cb.err_cnt,  2);
    send(4'd7, 4'd0, 4'd0, 4'd8, 4'b1000);
    check("t3b_err",     cb.flag_err, 1);
    check("t3b_val",     cb.win_val,  7);
    check("t3b_err_cnt", cb.err_cnt,  3);
    send(4'd1, 4'd2, 4'd3, 4'd4, 4'b0001);
    check("t3c_idx",   cb.win_idx,  3);
    check("t3c_val",   cb.win_val,  4);
    check("t3c_err",   cb.flag_err, 0);
    check("t3c_cnt_d", cb.cnt_d,    1);
    send(4'd5, 4'd5, 4'd5, 4'd6, 4'b1111);
    check("t3d_err",     cb.flag_err, 1);
    check("t3d_tie",     cb.all_tie,  0);
    check("t3d_tie_cnt", cb.tie_cnt,  1);
    check("t3d_err_cnt", cb.err_cnt,  4);
    send(4'd2, 4'd6, 4'd8, 4'd8, 4'b0010);
    check("t3e_idx",   cb.win_idx,  2);
    check("t3e_err",   cb.flag_err, 0);
    check("t3e_cnt_c", cb.cnt_c,    1);
    send(4'd2, 4'd6, 4'd8, 4'd8, 4'b0001);
    check("t3f_err",     cb.flag_err, 1);
    check("t3f_idx",     cb.win_idx,  3);
    check("t3f_val",     cb.win_val,  8);
    check("t3f_err_cnt", cb.err_cnt,  5);
    tick();
    check("t3_drain", cb.out_valid, 0);

    // backpressure hold, then release with a pending word and back-to-back
    cb.out_ready = 1'b0;
    send(4'd4, 4'd1, 4'd1, 4'd1, 4'b1000);
    check("t4_valid", cb.out_valid, 1);
    check("t4_cnt_a", cb.cnt_a, 1);
    set_word(4'd0, 4'd0, 4'd9, 4'd1, 4'b0010);
    cb.in_valid = 1'b1;
    #1;
    check("t4_in_ready_lo", cb.in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", cb.out_valid, 1);
      check("t4_hold_val",   cb.win_val,   4);
      check("t4_hold_idx",   cb.win_idx,   0);
      check("t4_hold_rdy",   cb.in_ready,  0);
    end
    check("t4_hold_cnt_c", cb.cnt_c, 1);
    cb.out_ready = 1'b1;
    #1;
    check("t4_in_ready_hi", cb.in_ready, 1);
    tick();
    check("t4_reload_valid", cb.out_valid, 1);
    check("t4_reload_idx",   cb.win_idx,   2);
    check("t4_reload_val",   cb.win_val,   9);
    check("t4_reload_cnt_c", cb.cnt_c,     2);
    set_word(4'd0, 4'd0, 4'd0, 4'd7, 4'b0001);
    tick();
    check("t4_b2b_idx",   cb.win_idx, 3);
    check("t4_b2b_val",   cb.win_val, 7);
    check("t4_b2b_cnt_d", cb.cnt_d,   2);
    cb.in_valid = 1'b0;
    tick();
    check("t4_empty", cb.out_valid, 0);

    // clear with a same-cycle accept on the 8-bit instance
    cb.clr_cnt = 1'b1;
    send(4'd3, 4'd9, 4'd2, 4'd9, 4'b0100);
    cb.clr_cnt = 1'b0;
    check("t5a_cnt_b",   cb.cnt_b,     0);
    check("t5a_err_cnt", cb.err_cnt,   0);
    check("t5a_valid",   cb.out_valid, 1);
    check("t5a_idx",     cb.win_idx,   1);

    // saturation and clear on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      send_s(4'd1, 4'd1, 4'd1, 4'd2, 4'b0001);
      if (i == 1) check("t5_cnt_d_2", sb.cnt_d, 2);
    end
    check("t5_cnt_d_sat", sb.cnt_d, 3);
    for (int i = 0; i < 4; i++) send_s(4'd1, 4'd2, 4'd3, 4'd4, 4'b1000);
    check("t5_err_sat", sb.err_cnt, 3);
    sb.clr_cnt = 1'b1;
    send_s(4'd1, 4'd1, 4'd1, 4'd2, 4'b0001);
    sb.clr_cnt = 1'b0;
    check("t5_clr_cnt_d", sb.cnt_d,     0);
    check("t5_clr_err",   sb.err_cnt,   0);
    check("t5_clr_valid", sb.out_valid, 1);
    check("t5_clr_idx",   sb.win_idx,   3);
    check("t5_clr_val",   sb.win_val,   2);
    send_s(4'd1, 4'd1, 4'd1, 4'd2, 4'b0001);
    check("t5_after_clr", sb.cnt_d, 1);

    // reset while holding a result
    cb.out_ready = 1'b0;
    send(4'd1, 4'd2, 4'd3, 4'd4, 4'b0001);
    check("t6_full",  cb.out_valid, 1);
    check("t6_cnt_d", cb.cnt_d,     1);
    rst_n = 1'b0;
    tick();
    check("t6_out_valid", cb.out_valid, 0);
    check("t6_idx",       cb.win_idx,   0);
    check("t6_val",       cb.win_val,   0);
    check("t6_err",       cb.flag_err,  0);
    check("t6_tie",       cb.all_tie,   0);
    check("t6_cnt_d",     cb.cnt_d,     0);
    check("t6_cnt_b",     cb.cnt_b,     0);
    check("t6_in_ready",  cb.in_ready,  1);
    rst_n = 1'b1;
    cb.out_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
